// File: rtl/aibcr3_dcc_updn_filter.sv
// aibcr3_dcc_updn_filter: DCC loop filter integrating phase-detector votes into a delay-line code,
// with dither-based lock detection and rail saturation flags.
module aibcr3_dcc_updn_filter #(
    parameter int CODE_W     = 6,
    parameter int CODE_INIT  = 32,
    parameter int LIMIT      = 4,
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 3
) (
    input  logic              CLKB,
    input  logic              RSTb,
    input  logic              dcc_en,
    input  logic              t_up,
    input  logic              t_down,
    output logic [CODE_W-1:0] code_out,
    output logic              code_upd,
    output logic              dcc_lock,
    output logic              sat_hi,
    output logic              sat_lo
);
    localparam int AW = $clog2(LIMIT) + 2;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, TRACK, LOCK} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t               state_q;
    dir_t                 last_q, dir_d;
    logic signed [AW-1:0] acc_q, acc_d, vote;
    logic [SW-1:0]        settle_q;
    logic [RW-1:0]        rev_q;
    logic [LW-1:0]        same_q;
    logic [CODE_W-1:0]    code_q;
    logic                 upd_q, lock_q, sat_hi_q, sat_lo_q;
    logic                 tracking, inc, dec, req, rev, same, at_max, at_min;

    always_comb begin
        tracking = state_q == TRACK || state_q == LOCK;
        vote     = (!tracking || t_up == t_down) ? '0 : (t_up ? AW'(1) : AW'(-1));
        acc_d    = acc_q + vote;
        inc      = acc_d == AW'(LIMIT);
        dec      = acc_d == AW'(-LIMIT);
        req      = inc || dec;
        dir_d    = inc ? DIR_UP : DIR_DN;
        rev      = req && last_q != DIR_NONE && last_q != dir_d;
        same     = req && last_q == dir_d;
        at_max   = &code_q;
        at_min   = ~|code_q;
    end

    assign code_out = code_q;
    assign code_upd = upd_q;
    assign dcc_lock = lock_q;
    assign sat_hi   = sat_hi_q;
    assign sat_lo   = sat_lo_q;

    always_ff @(posedge CLKB or negedge RSTb) begin
        if (!RSTb) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            settle_q <= '0;
            rev_q    <= '0;
            same_q   <= '0;
            last_q   <= DIR_NONE;
            code_q   <= CODE_W'(CODE_INIT);
            upd_q    <= 1'b0;
            lock_q   <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (!dcc_en) begin
                state_q <= IDLE;
                acc_q   <= '0;
                rev_q   <= '0;
                same_q  <= '0;
                last_q  <= DIR_NONE;
                lock_q  <= 1'b0;
            end else case (state_q)
                IDLE: begin
                    state_q  <= SETTLE;
                    settle_q <= '0;
                end
                SETTLE: begin
                    settle_q <= settle_q + SW'(1);
                    last_q   <= DIR_NONE;
                    if (settle_q == SW'(SETTLE_CYC - 1)) state_q <= TRACK;
                end
                default: begin
                    acc_q <= req ? '0 : acc_d;
                    if (inc) begin
                        if (at_max) sat_hi_q <= 1'b1;
                        else begin
                            code_q   <= code_q + CODE_W'(1);
                            upd_q    <= 1'b1;
                            sat_lo_q <= 1'b0;
                        end
                    end
                    if (dec) begin
                        if (at_min) sat_lo_q <= 1'b1;
                        else begin
                            code_q   <= code_q - CODE_W'(1);
                            upd_q    <= 1'b1;
                            sat_hi_q <= 1'b0;
                        end
                    end
                    if (req) last_q <= dir_d;
                    // blocked requests still count toward lock accounting
                    if (rev) begin
                        same_q <= '0;
                        if (state_q == TRACK && rev_q == RW'(LOCK_CNT - 1)) begin
                            state_q <= LOCK;
                            lock_q  <= 1'b1;
                            rev_q   <= '0;
                        end else if (rev_q != RW'(LOCK_CNT)) rev_q <= rev_q + RW'(1);
                    end
                    if (same) begin
                        rev_q <= '0;
                        if (state_q == LOCK && same_q == LW'(LOSS_CNT - 1)) begin
                            state_q <= TRACK;
                            lock_q  <= 1'b0;
                            same_q  <= '0;
                        end else if (same_q != LW'(LOSS_CNT)) same_q <= same_q + LW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aibcr3_dcc_updn_filter.sv
// tb_aibcr3_dcc_updn_filter: scoreboard bench with an integer reference model of the DCC loop filter.
module tb_aibcr3_dcc_updn_filter;
    localparam int CODE_INIT = 32, LIMIT = 4, SETTLE_CYC = 8, LOCK_CNT = 4, LOSS_CNT = 3, CMAX = 63;

    logic       CLKB = 1'b0, RSTb = 1'b1, dcc_en = 1'b0, t_up = 1'b0, t_down = 1'b0;
    logic [5:0] code_out;
    logic       code_upd, dcc_lock, sat_hi, sat_lo;
    int         checks = 0, errors = 0;
    logic [9:0] expq[$];

    int m_phase, m_settle, m_acc, m_code, m_last, m_rev, m_same;
    bit m_upd, m_lock, m_shi, m_slo;

    always #5 CLKB = ~CLKB;

    aibcr3_dcc_updn_filter dut (
        .CLKB(CLKB), .RSTb(RSTb), .dcc_en(dcc_en), .t_up(t_up), .t_down(t_down),
        .code_out(code_out), .code_upd(code_upd), .dcc_lock(dcc_lock), .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    function automatic logic [9:0] outs();
        return {code_out, code_upd, dcc_lock, sat_hi, sat_lo};
    endfunction

    function automatic logic [9:0] m_vec();
        return {6'(m_code), m_upd, m_lock, m_shi, m_slo};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = 0; m_settle = 0; m_acc = 0; m_code = CODE_INIT; m_last = 0;
        m_rev = 0; m_same = 0; m_upd = 0; m_lock = 0; m_shi = 0; m_slo = 0;
    endtask

    // one code-step request in direction dir (+1/-1)
    task automatic m_request(int dir);
        if (dir > 0) begin
            if (m_code == CMAX) m_shi = 1;
            else begin m_code++; m_upd = 1; m_slo = 0; end
        end else begin
            if (m_code == 0) m_slo = 1;
            else begin m_code--; m_upd = 1; m_shi = 0; end
        end
        if (m_last != 0) begin
            if (dir != m_last) begin
                m_rev++; m_same = 0;
                if (!m_lock && m_rev == LOCK_CNT) begin m_lock = 1; m_rev = 0; end
            end else begin
                m_same++; m_rev = 0;
                if (m_lock && m_same == LOSS_CNT) begin m_lock = 0; m_same = 0; end
            end
        end
        m_last = dir;
    endtask

    task automatic m_edge(bit en, bit up, bit dn);
        int d;
        m_upd = 0;
        if (!en) begin
            m_phase = 0; m_acc = 0; m_rev = 0; m_same = 0; m_last = 0; m_lock = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_settle = 0;
        end else if (m_phase == 1) begin
            m_settle++;
            if (m_settle == SETTLE_CYC) begin m_phase = 2; m_last = 0; end
        end else begin
            m_acc += int'(up) - int'(dn);
            if (m_acc == LIMIT || m_acc == -LIMIT) begin
                d = m_acc > 0 ? 1 : -1;
                m_acc = 0;
                m_request(d);
            end
        end
    endtask

    task automatic step(bit en, bit up, bit dn);
        dcc_en = en; t_up = up; t_down = dn;
        @(posedge CLKB);
        m_edge(en, up, dn);
        expq.push_back(m_vec());
        @(negedge CLKB);
    endtask

    task automatic do_reset();
        #2 RSTb = 1'b0;
        #1;
        m_reset();
        chk("async_reset_outs", int'(outs()), int'(m_vec()));
        dcc_en = 0; t_up = 0; t_down = 0;
        @(negedge CLKB);
        @(negedge CLKB);
        RSTb = 1'b1;
    endtask

    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge CLKB);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("outs{code,upd,lock,sat_hi,sat_lo}", int'(outs()), int'(e));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        bit en, up, dn;
        int p;
        do_reset();
        repeat (13) step(1, 1, 0);
        chk("ramp_first_code", int'(code_out), 33);
        chk("ramp_first_upd", int'(code_upd), 1);
        repeat (120) step(1, 1, 0);
        chk("ramp_top_code", int'(code_out), 63);
        repeat (4) step(1, 1, 0);
        chk("sat_hi_set", int'(sat_hi), 1);
        chk("sat_hi_no_upd", int'(code_upd), 0);
        chk("sat_hi_code", int'(code_out), 63);
        repeat (4) step(1, 0, 1);
        chk("sat_hi_clear", int'(sat_hi), 0);
        chk("step_down_code", int'(code_out), 62);

        do_reset();
        repeat (13) step(1, 1, 0);
        for (int g = 0; g < 4; g++) begin
            repeat (4) step(1, g % 2 == 1, g % 2 == 0);
            chk("dither_lock", int'(dcc_lock), int'(g == 3));
        end
        chk("lock_code", int'(code_out), 33);
        for (int g = 1; g <= 3; g++) begin
            repeat (4) step(1, 1, 0);
            chk("loss_lock", int'(dcc_lock), int'(g < 3));
            chk("loss_code", int'(code_out), 33 + g);
        end

        repeat (20) step(1, 1, 1);
        repeat (20) step(1, 0, 0);
        for (int i = 0; i < 40; i++) step(1, (i % 6) < 3, (i % 6) >= 3);
        chk("null_code", int'(code_out), 36);
        step(1, 1, 0);
        step(0, 0, 0);
        chk("disable_lock", int'(dcc_lock), 0);
        repeat (12) step(1, 1, 0);
        chk("reen_no_step", int'(code_out), 36);
        step(1, 1, 0);
        chk("reen_step", int'(code_out), 37);

        do_reset();
        repeat (150) step(1, 0, 1);
        chk("sat_lo_code", int'(code_out), 0);
        chk("sat_lo_set", int'(sat_lo), 1);

        do_reset();
        for (int b = 0; b < 10; b++) begin
            p = $urandom_range(20, 80);
            repeat (200) begin
                en = $urandom_range(0, 199) != 0;
                up = $urandom_range(0, 99) < p;
                dn = $urandom_range(0, 99) >= p;
                step(en, up, dn);
            end
        end

        do_reset();
        repeat (41) step(1, 1, 0);
        chk("pre_lock_code", int'(code_out), 40);
        for (int g = 0; g < 4; g++) repeat (4) step(1, g % 2 == 1, g % 2 == 0);
        chk("lock40", int'(dcc_lock), 1);
        chk("lock40_code", int'(code_out), 40);
        do_reset();
        chk("rst_code", int'(code_out), 32);

        repeat (2) @(negedge CLKB);
        chk("scoreboard_drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
